// File: rtl/gates_result_scan.sv
// Snapshots the five gate results on a capture strobe and shows one of them at a time.
// The selection advances on a synchronized step-button edge or on a periodic auto-scan tick.
module gates_result_scan #(
   parameter int WIDTH    = 4,
   parameter int SCAN_DIV = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] y1,
   input  logic [WIDTH-1:0] y2,
   input  logic [WIDTH-1:0] y3,
   input  logic [WIDTH-1:0] y4,
   input  logic [WIDTH-1:0] y5,
   input  logic             capture,
   input  logic             step,
   input  logic             auto_en,
   output logic [WIDTH-1:0] sel_out,
   output logic [2:0]       sel_idx,
   output logic [4:0]       sel_onehot,
   output logic             valid
);

   localparam int            CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [WIDTH-1:0] snap0_q, snap1_q, snap2_q, snap3_q, snap4_q;
   logic [WIDTH-1:0] snap0_d, snap1_d, snap2_d, snap3_d, snap4_d;
   logic [2:0]       idx_q, idx_d;
   logic             valid_q, valid_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             s1_q, s2_q, s3_q;
   logic             step_pulse;
   logic             tick;

   // s1/s2 resynchronize the raw button level; s3 delays s2 to find its rising edge
   assign step_pulse = s2_q & ~s3_q;
   assign tick       = valid_q & auto_en & (cnt_q == CNT_LAST);

   always_comb begin
      snap0_d = snap0_q;
      snap1_d = snap1_q;
      snap2_d = snap2_q;
      snap3_d = snap3_q;
      snap4_d = snap4_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      cnt_d   = '0;
      if (capture) begin
         snap0_d = y1;
         snap1_d = y2;
         snap2_d = y3;
         snap3_d = y4;
         snap4_d = y5;
         idx_d   = 3'd0;
         valid_d = 1'b1;
      end else if (valid_q) begin
         if (step_pulse | tick) begin
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
         end
         // A manual step restarts the auto period so the next tick is a full period away
         if (auto_en && !step_pulse && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap0_q <= '0;
         snap1_q <= '0;
         snap2_q <= '0;
         snap3_q <= '0;
         snap4_q <= '0;
         idx_q   <= 3'd0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
      end else begin
         snap0_q <= snap0_d;
         snap1_q <= snap1_d;
         snap2_q <= snap2_d;
         snap3_q <= snap3_d;
         snap4_q <= snap4_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         s1_q    <= step;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
      end
   end

   always_comb begin
      case (idx_q)
         3'd0:    sel_out = snap0_q;
         3'd1:    sel_out = snap1_q;
         3'd2:    sel_out = snap2_q;
         3'd3:    sel_out = snap3_q;
         3'd4:    sel_out = snap4_q;
         default: sel_out = '0;
      endcase
   end

   assign sel_idx    = idx_q;
   assign valid      = valid_q;
   assign sel_onehot = valid_q ? (5'b00001 << idx_q) : 5'b00000;

endmodule

// File: tb/tb_gates_result_scan.sv
// Bench for gates_result_scan: directed scenarios plus a random phase, each cycle checked
// against a reference model that tracks snapshots, selection and auto-scan phase.
module tb_gates_result_scan;

   localparam int WIDTH    = 4;
   localparam int SCAN_DIV = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] y1, y2, y3, y4, y5;
   logic             capture, step, auto_en;
   logic [WIDTH-1:0] sel_out;
   logic [2:0]       sel_idx;
   logic [4:0]       sel_onehot;
   logic             valid;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [WIDTH-1:0] m_snap [5];
   int               m_idx;
   bit               m_valid;
   int               m_cnt;
   bit               hist [$];

   gates_result_scan #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n),
      .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
      .capture(capture), .step(step), .auto_en(auto_en),
      .sel_out(sel_out), .sel_idx(sel_idx), .sel_onehot(sel_onehot), .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_snap[i] = '0;
      m_idx   = 0;
      m_valid = 0;
      m_cnt   = 0;
      hist    = '{0, 0, 0};
   endtask

   // hist[0] = step level seen at the previous edge, hist[1] two edges back, ...
   task automatic model_edge();
      bit pulse, tick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pulse = hist[1] && !hist[2];
      tick  = m_valid && auto_en && (m_cnt == SCAN_DIV - 1);
      if (capture) begin
         m_snap  = '{y1, y2, y3, y4, y5};
         m_idx   = 0;
         m_valid = 1;
         m_cnt   = 0;
      end else if (m_valid) begin
         if (pulse || tick) m_idx = (m_idx + 1) % 5;
         if (!auto_en || pulse) m_cnt = 0;
         else m_cnt = (m_cnt + 1) % SCAN_DIV;
      end
      hist.push_front(bit'(step));
      void'(hist.pop_back());
   endtask

   task automatic check_all();
      chk("sel_out", 32'(sel_out), 32'(m_snap[m_idx]));
      chk("sel_idx", 32'(sel_idx), 32'(m_idx));
      chk("sel_onehot", 32'(sel_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
      chk("valid", 32'(valid), 32'(m_valid));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_capture(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      y1 = a & b; y2 = a | b; y3 = a ^ b; y4 = ~(a & b); y5 = ~(a | b);
      capture = 1'b1;
      cycle();
      capture = 1'b0;
      y1 = 4'($urandom_range(0, 15)); y2 = 4'($urandom_range(0, 15));
      y3 = 4'($urandom_range(0, 15)); y4 = 4'($urandom_range(0, 15));
      y5 = 4'($urandom_range(0, 15));
   endtask

   // press held 5 cycles, released 5 cycles; selection must move exactly at the 3rd edge
   task automatic press();
      int old_idx;
      old_idx = m_idx;
      step = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         if (c == 6) step = 1'b0;
         cycle();
         if (c <= 5) chk("step_latency", 32'(sel_idx), (c < 3) ? 32'(old_idx) : 32'((old_idx + 1) % 5));
      end
   endtask

   initial begin
      logic [WIDTH-1:0] exp_seq [5];
      logic [WIDTH-1:0] cap_y1;
      rst_n = 1'b0; capture = 1'b0; step = 1'b0; auto_en = 1'b0;
      y1 = '0; y2 = '0; y3 = '0; y4 = '0; y5 = '0;
      model_reset();
      repeat (3) cycle();
      chk("reset_sel_out", 32'(sel_out), 32'd0);
      chk("reset_onehot", 32'(sel_onehot), 32'd0);
      rst_n = 1'b1;

      // idle without capture: step and auto-scan must be ignored
      auto_en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step = (c % 6) < 3;
         y1 = 4'($urandom_range(0, 15));
         cycle();
         chk("idle_valid", 32'(valid), 32'd0);
         chk("idle_idx", 32'(sel_idx), 32'd0);
      end
      step = 1'b0; auto_en = 1'b0;
      repeat (4) cycle();

      // capture of a=1100, b=1010
      do_capture(4'b1100, 4'b1010);
      chk("cap_valid", 32'(valid), 32'd1);
      chk("cap_idx", 32'(sel_idx), 32'd0);
      chk("cap_sel_out", 32'(sel_out), 32'b1000);
      chk("cap_onehot", 32'(sel_onehot), 32'b00001);

      exp_seq = '{4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1000};
      for (int p = 0; p < 5; p++) begin
         press();
         chk("press_sel_out", 32'(sel_out), 32'(exp_seq[p]));
      end

      // auto-scan every SCAN_DIV cycles
      auto_en = 1'b1;
      do_capture(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int c = 1; c <= 20; c++) begin
         cycle();
         chk("auto_idx", 32'(sel_idx), 32'((c / 4) % 5));
      end
      repeat (2) cycle();
      auto_en = 1'b0;
      repeat (3) cycle();
      chk("auto_hold", 32'(sel_idx), 32'd0);
      auto_en = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         cycle();
         chk("auto_restart", 32'(sel_idx), (c == 4) ? 32'd1 : 32'd0);
      end

      // capture coincident with step pulse at idx 3
      auto_en = 1'b0;
      do_capture(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat (3) press();
      chk("pre_coll_idx", 32'(sel_idx), 32'd3);
      step = 1'b1;
      repeat (2) cycle();
      cap_y1 = 4'b0101 & 4'b0011;
      do_capture(4'b0101, 4'b0011);
      chk("coll_cap_idx", 32'(sel_idx), 32'd0);
      chk("coll_cap_out", 32'(sel_out), 32'(cap_y1));
      repeat (3) cycle();
      chk("coll_no_adv", 32'(sel_idx), 32'd0);
      step = 1'b0;
      repeat (3) cycle();

      // step pulse coincident with tick at idx 1
      auto_en = 1'b1;
      do_capture(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat (5) cycle();
      chk("tick_idx1", 32'(sel_idx), 32'd1);
      step = 1'b1;
      repeat (3) cycle();
      chk("coll_tick_idx", 32'(sel_idx), 32'd2);
      step = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         cycle();
         chk("coll_tick_cnt", 32'(sel_idx), (c == 4) ? 32'd3 : 32'd2);
      end
      // mid-period step restarts the auto period
      step = 1'b1;
      repeat (3) cycle();
      chk("mid_step_idx", 32'(sel_idx), 32'd4);
      step = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         cycle();
         chk("mid_step_restart", 32'(sel_idx), (c == 4) ? 32'd0 : 32'd4);
      end

      // async reset mid-scan at idx 2
      auto_en = 1'b0;
      do_capture(4'b1111, 4'b0110);
      repeat (2) press();
      auto_en = 1'b1;
      repeat (2) cycle();
      chk("pre_rst_idx", 32'(sel_idx), 32'd2);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_sel_out", 32'(sel_out), 32'd0);
      chk("arst_idx", 32'(sel_idx), 32'd0);
      chk("arst_onehot", 32'(sel_onehot), 32'd0);
      chk("arst_valid", 32'(valid), 32'd0);
      step = 1'b1;
      @(negedge clk);
      repeat (2) cycle();
      rst_n = 1'b1;
      auto_en = 1'b0;
      repeat (3) cycle();
      do_capture(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat (6) cycle();
      chk("held_step_no_adv", 32'(sel_idx), 32'd0);
      step = 1'b0;
      repeat (3) cycle();
      press();
      chk("repress_idx", 32'(sel_idx), 32'd1);

      // random phase against the model
      for (int c = 0; c < 400; c++) begin
         y1 = 4'($urandom_range(0, 15)); y2 = 4'($urandom_range(0, 15));
         y3 = 4'($urandom_range(0, 15)); y4 = 4'($urandom_range(0, 15));
         y5 = 4'($urandom_range(0, 15));
         capture = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0) step = ~step;
         if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
